// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter/sequencer sharing a single-ported unified
//               memory between instruction fetch (read-only) and data access
//               (read/write). One access in flight, full REQ/ACK handshake per
//               port. Owns CS/WE/ADDR and the tristate write driver on MEM_BUS.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_WORDS = 128,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    // Instruction fetch port (read-only)
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_ACK,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_ERR,
    // Data port (read/write)
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_ACK,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ERR,
    // Memory side
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    inout  wire  [DATA_W-1:0] MEM_BUS,
    output logic              BUSY
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_resp  = 2'd2;

    localparam logic [ADDR_W-1:0] c_mem_words = ADDR_W'(MEM_WORDS);

    logic [1:0]        state_q,    state_d;
    logic              gnt_d_q,    gnt_d_d;     // granted port: 1 = D, 0 = IF
    logic              last_d_q,   last_d_d;    // last grant went to D
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    logic              acking_if;
    logic              acking_d;
    logic              elig_if;
    logic              elig_d;
    logic              grant_valid;
    logic              grant_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic              bus_drive;

    // Arbitration: a port being acknowledged this cycle cannot be re-granted,
    // which forces an idle cycle between same-port accesses.
    always_comb begin
        acking_if   = (state_q == c_resp) && !gnt_d_q;
        acking_d    = (state_q == c_resp) &&  gnt_d_q;
        elig_if     = IF_REQ && (state_q != c_issue) && !acking_if;
        elig_d      = D_REQ  && (state_q != c_issue) && !acking_d;
        grant_valid = elig_if || elig_d;
        grant_d     = elig_d && (!elig_if || !last_d_q);
        sel_addr    = grant_d ? D_ADDR : IF_ADDR;
        sel_err     = (sel_addr >= c_mem_words);
    end

    // Next-state and datapath: latch the granted access, capture read data
    // at the end of ISSUE, zero read data on writes and out-of-range errors.
    always_comb begin
        state_d    = state_q;
        gnt_d_d    = gnt_d_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            c_idle, c_resp: begin
                if (grant_valid) begin
                    gnt_d_d  = grant_d;
                    last_d_d = grant_d;
                    addr_d   = sel_addr;
                    we_d     = grant_d && D_WE;
                    wdata_d  = grant_d ? D_WDATA : '0;
                    err_d    = sel_err;
                    if (sel_err) begin
                        // No memory cycle: acknowledge with error next cycle.
                        state_d = c_resp;
                        if (grant_d) begin
                            d_rdata_d = '0;
                        end else begin
                            if_rdata_d = '0;
                        end
                    end else begin
                        state_d = c_issue;
                    end
                end else begin
                    state_d = c_idle;
                end
            end
            c_issue: begin
                state_d = c_resp;
                if (gnt_d_q) begin
                    d_rdata_d = we_q ? '0 : MEM_BUS;
                end else begin
                    if_rdata_d = MEM_BUS;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    // Controller state; async reset aborts any in-flight access without ACK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= c_idle;
            gnt_d_q    <= 1'b0;
            last_d_q   <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_d_q    <= gnt_d_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Output decode; memory controls are derived from state so that reset
    // drops MEM_CS immediately, before the memory's negedge.
    always_comb begin
        IF_ACK    = acking_if;
        D_ACK     = acking_d;
        IF_ERR    = acking_if && err_q;
        D_ERR     = acking_d  && err_q;
        IF_RDATA  = if_rdata_q;
        D_RDATA   = d_rdata_q;
        MEM_CS    = (state_q == c_issue);
        MEM_WE    = (state_q == c_issue) && we_q;
        MEM_ADDR  = (state_q == c_issue) ? addr_q : '0;
        BUSY      = (state_q == c_issue) || (state_q == c_resp);
        bus_drive = (state_q == c_issue) && we_q;
    end

    // Bus is driven only during a write ISSUE, never while memory reads.
    assign MEM_BUS = bus_drive ? wdata_q : {DATA_W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a behavioural
//               negedge memory model, directed vector table and hand-written
//               multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int MEM_WORDS = 128;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;

    logic              CLK;
    logic              RST_N;
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_ACK;
    logic [DATA_W-1:0] IF_RDATA;
    logic              IF_ERR;
    logic              D_REQ;
    logic              D_WE;
    logic [ADDR_W-1:0] D_ADDR;
    logic [DATA_W-1:0] D_WDATA;
    logic              D_ACK;
    logic [DATA_W-1:0] D_RDATA;
    logic              D_ERR;
    logic              MEM_CS;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    wire  [DATA_W-1:0] MEM_BUS;
    logic              BUSY;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IF_REQ   (IF_REQ),
        .IF_ADDR  (IF_ADDR),
        .IF_ACK   (IF_ACK),
        .IF_RDATA (IF_RDATA),
        .IF_ERR   (IF_ERR),
        .D_REQ    (D_REQ),
        .D_WE     (D_WE),
        .D_ADDR   (D_ADDR),
        .D_WDATA  (D_WDATA),
        .D_ACK    (D_ACK),
        .D_RDATA  (D_RDATA),
        .D_ERR    (D_ERR),
        .MEM_CS   (MEM_CS),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_BUS  (MEM_BUS),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: acts on negedge, drives read data while selected for read.
    logic [DATA_W-1:0] ram [0:MEM_WORDS-1];
    logic [DATA_W-1:0] rd_q;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            ram[i] <= 32'h1000_0000 + i;
        end
        ram[3] <= 32'h2402_000A;
        rd_q   <= '0;
    end

    always @(negedge CLK) begin
        if (MEM_CS) begin
            if (MEM_WE) begin
                ram[MEM_ADDR[6:0]] <= MEM_BUS;
            end else begin
                rd_q <= ram[MEM_ADDR[6:0]];
            end
        end
    end

    assign MEM_BUS = (MEM_CS && !MEM_WE) ? rd_q : {DATA_W{1'bz}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic is_d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err);
        vec_t v;
        v.is_d = is_d; v.we = we; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Single isolated transaction from IDLE; checks latency, data, error, CS.
    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        logic        ackd;
        logic        cs_seen;
        logic [31:0] rd;
        logic        er;
        n = 0; ackd = 1'b0; cs_seen = 1'b0; rd = '0; er = 1'b0;
        @(posedge CLK); #1;
        if (v.is_d) begin
            D_REQ = 1'b1; D_WE = v.we; D_ADDR = v.addr; D_WDATA = v.wdata;
        end else begin
            IF_REQ = 1'b1; IF_ADDR = v.addr;
        end
        while (!ackd && n < 10) begin
            @(posedge CLK); #1;
            n++;
            if (MEM_CS) begin
                cs_seen = 1'b1;
                chk($sformatf("vec%0d mem_addr", idx), MEM_ADDR, v.addr);
                if (v.we) chk($sformatf("vec%0d mem_bus", idx), MEM_BUS, v.wdata);
            end
            ackd = v.is_d ? D_ACK : IF_ACK;
            if (ackd) begin
                rd = v.is_d ? D_RDATA : IF_RDATA;
                er = v.is_d ? D_ERR   : IF_ERR;
            end
        end
        D_REQ = 1'b0; IF_REQ = 1'b0;
        chk($sformatf("vec%0d latency", idx), n, v.exp_err ? 32'd1 : 32'd2);
        chk($sformatf("vec%0d rdata", idx), rd, v.exp_rdata);
        chk($sformatf("vec%0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
        chk($sformatf("vec%0d cs_seen", idx), {31'd0, cs_seen}, {31'd0, !v.exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack_seen;
        RST_N = 1'b0; IF_REQ = 1'b0; IF_ADDR = '0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;

        vecs[0] = mk(1'b0, 1'b0, 32'd3,   32'h0,         32'h2402_000A, 1'b0);
        vecs[1] = mk(1'b1, 1'b1, 32'd64,  32'hDEAD_BEEF, 32'h0,         1'b0);
        vecs[2] = mk(1'b1, 1'b0, 32'd64,  32'h0,         32'hDEAD_BEEF, 1'b0);
        vecs[3] = mk(1'b1, 1'b0, 32'd128, 32'h0,         32'h0,         1'b1);
        vecs[4] = mk(1'b0, 1'b0, 32'd200, 32'h0,         32'h0,         1'b1);
        vecs[5] = mk(1'b1, 1'b1, 32'd127, 32'h1234_5678, 32'h0,         1'b0);
        vecs[6] = mk(1'b0, 1'b0, 32'd127, 32'h0,         32'h1234_5678, 1'b0);
        vecs[7] = mk(1'b1, 1'b0, 32'd3,   32'h0,         32'h2402_000A, 1'b0);

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst if_ack",   {31'd0, IF_ACK}, 32'd0);
        chk("rst d_ack",    {31'd0, D_ACK},  32'd0);
        chk("rst if_err",   {31'd0, IF_ERR}, 32'd0);
        chk("rst d_err",    {31'd0, D_ERR},  32'd0);
        chk("rst mem_cs",   {31'd0, MEM_CS}, 32'd0);
        chk("rst mem_we",   {31'd0, MEM_WE}, 32'd0);
        chk("rst mem_addr", MEM_ADDR, 32'd0);
        chk("rst busy",     {31'd0, BUSY},   32'd0);
        chk("rst if_rdata", IF_RDATA, 32'd0);
        chk("rst d_rdata",  D_RDATA,  32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Both ports requesting constantly: IF first, then alternate.
        @(posedge CLK); #1;
        IF_REQ = 1'b1; IF_ADDR = 32'd10;
        D_REQ  = 1'b1; D_WE = 1'b0; D_ADDR = 32'd20;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("alt%0d if_ack", k), {31'd0, IF_ACK}, {31'd0, (k % 4) == 2});
            chk($sformatf("alt%0d d_ack", k),  {31'd0, D_ACK},  {31'd0, (k % 4) == 0});
            chk($sformatf("alt%0d busy", k),   {31'd0, BUSY},   32'd1);
            if (IF_ACK) chk($sformatf("alt%0d if_rdata", k), IF_RDATA, 32'h1000_000A);
            if (D_ACK)  chk($sformatf("alt%0d d_rdata", k),  D_RDATA,  32'h1000_0014);
        end
        IF_REQ = 1'b0; D_REQ = 1'b0;
        repeat (2) @(posedge CLK);

        // Directed single-transaction vectors
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a write ISSUE to address 5
        @(posedge CLK); #1;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'd5; D_WDATA = 32'hBAD0_BAD0;
        @(posedge CLK); #1;
        chk("abort cs_before", {31'd0, MEM_CS}, 32'd1);
        #1 RST_N = 1'b0;
        #1;
        chk("abort cs_after", {31'd0, MEM_CS}, 32'd0);
        chk("abort we_after", {31'd0, MEM_WE}, 32'd0);
        chk("abort busy",     {31'd0, BUSY},   32'd0);
        D_REQ = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
            ack_seen = ack_seen | IF_ACK | D_ACK;
        end
        chk("abort no_ack", {31'd0, ack_seen}, 32'd0);
        chk("abort ram5",   ram[5], 32'h1000_0005);
        @(negedge CLK);
        RST_N = 1'b1;

        // D write 127, IF read 127 raised in the RESP cycle -> issued next cycle
        @(posedge CLK); #1;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'd127; D_WDATA = 32'hCAFE_F00D;
        @(posedge CLK); #1;
        chk("b2b wr cs",  {31'd0, MEM_CS}, 32'd1);
        chk("b2b wr bus", MEM_BUS, 32'hCAFE_F00D);
        @(posedge CLK); #1;
        chk("b2b d_ack",    {31'd0, D_ACK}, 32'd1);
        chk("b2b d_rdata",  D_RDATA, 32'd0);
        D_REQ = 1'b0;
        IF_REQ = 1'b1; IF_ADDR = 32'd127;
        @(posedge CLK); #1;
        chk("b2b rd cs",   {31'd0, MEM_CS}, 32'd1);
        chk("b2b rd we",   {31'd0, MEM_WE}, 32'd0);
        chk("b2b rd addr", MEM_ADDR, 32'd127);
        @(posedge CLK); #1;
        chk("b2b if_ack",   {31'd0, IF_ACK}, 32'd1);
        chk("b2b d_ack2",   {31'd0, D_ACK},  32'd0);
        chk("b2b if_rdata", IF_RDATA, 32'hCAFE_F00D);
        chk("b2b if_err",   {31'd0, IF_ERR}, 32'd0);
        IF_REQ = 1'b0;
        repeat (2) @(posedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
